// File: rtl/jtdd_scan2x_pkg.sv
// Shared constants for the jtdd 15 kHz -> 31 kHz line doubler.
// The line-buffer word is the 4-4-4 pixel with the horizontal blank bit on top.
package jtdd_scan2x_pkg;

    localparam int HLEN_DEF = 512;
    localparam int COLOR_W  = 4;
    localparam int PXL_W    = 3 * COLOR_W;
    localparam int WORD_W   = PXL_W + 1;
    localparam int LHBL_BIT = WORD_W - 1;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic             lhbl,
        input logic [PXL_W-1:0] rgb
    );
        return {lhbl, rgb};
    endfunction

endpackage

// File: rtl/jtdd_scan2x_lbuf.sv
// Ping-pong line buffer: two banks of HLEN words, bank chosen by the address MSB.
// One write port and one registered read port; the read register holds between enables.
module jtdd_scan2x_lbuf
    import jtdd_scan2x_pkg::*;
#(
    parameter int HLEN = HLEN_DEF,
    parameter int W    = WORD_W
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [$clog2(HLEN):0]  wr_addr,
    input  logic [W-1:0]           wr_data,
    input  logic                   re,
    input  logic [$clog2(HLEN):0]  rd_addr,
    output logic [W-1:0]           rd_data
);

    logic [W-1:0] mem [0:2*HLEN-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/jtdd_scan2x.sv
// Line doubler: each 15 kHz input line is stored in one bank while the previous
// line is replayed twice from the other bank at double pixel rate.
module jtdd_scan2x
    import jtdd_scan2x_pkg::*;
#(
    parameter int HLEN = HLEN_DEF,
    parameter int DW   = PXL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pxl_cen,
    input  logic               pxl2_cen,
    input  logic [COLOR_W-1:0] red,
    input  logic [COLOR_W-1:0] green,
    input  logic [COLOR_W-1:0] blue,
    input  logic               HS,
    input  logic               LHBL_dly,
    input  logic               LVBL_dly,
    output logic [COLOR_W-1:0] x_red,
    output logic [COLOR_W-1:0] x_green,
    output logic [COLOR_W-1:0] x_blue,
    output logic               x_HS,
    output logic               x_LHBL,
    output logic               x_LVBL
);

    localparam int AW = $clog2(HLEN);
    localparam int WW = DW + 1;

    typedef logic [AW-1:0] addr_t;

    localparam addr_t ADDR_MAX = addr_t'(HLEN - 1);
    localparam addr_t ADDR_ONE = addr_t'(1);
    localparam addr_t ADDR_TWO = addr_t'(2);

    function automatic addr_t sat_inc(input addr_t a);
        return (a == ADDR_MAX) ? a : addr_t'(a + 1'b1);
    endfunction

    function automatic addr_t wrap_inc(input addr_t a, input addr_t len);
        if (len < ADDR_TWO) begin
            return '0;
        end
        return (a == addr_t'(len - 1'b1)) ? '0 : addr_t'(a + 1'b1);
    endfunction

    // Write-side state
    addr_t       wr_addr;
    addr_t       line_len;
    addr_t       hs_len;
    addr_t       hs_out_len;
    logic        wr_bank;
    logic        hs_last;
    logic        vbl_line;
    logic        vbl_prev;
    logic [1:0]  sync_cnt;

    logic        hs_rise;
    logic        hs_fall;
    logic [WW-1:0] wr_word;
    logic [AW:0] ram_wr_addr;

    // Read-side state
    addr_t       rd_addr;
    addr_t       line_len_eff;
    addr_t       rd_base;
    logic        rd_bank;
    logic        vbl_eff;
    logic        vld_eff;
    logic        short_eff;
    logic [AW:0] ram_rd_addr;

    logic [WW-1:0] word_p1;
    logic          vld_p1;
    logic          short_p1;
    logic          hs_p1;
    logic          vbl_p1;

    logic [DW-1:0] rgb_o;
    logic          hs_o;
    logic          lhbl_o;
    logic          lvbl_o;

    assign hs_rise = pxl_cen &  HS & ~hs_last;
    assign hs_fall = pxl_cen & ~HS &  hs_last;

    // The pixel arriving with the sync edge opens the new bank at address 0.
    assign wr_word     = pack_word(LHBL_dly, {red, green, blue});
    assign ram_wr_addr = hs_rise ? {~wr_bank, addr_t'(0)} : {wr_bank, wr_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            line_len   <= '0;
            hs_len     <= '0;
            hs_out_len <= '0;
            wr_bank    <= 1'b0;
            hs_last    <= 1'b0;
            vbl_line   <= 1'b0;
            vbl_prev   <= 1'b0;
            sync_cnt   <= 2'd0;
        end else if (pxl_cen) begin
            hs_last <= HS;
            if (hs_rise) begin
                line_len <= wr_addr;
                wr_bank  <= ~wr_bank;
                wr_addr  <= ADDR_ONE;
                hs_len   <= ADDR_ONE;
                vbl_line <= LVBL_dly;
                vbl_prev <= vbl_line;
                if (sync_cnt != 2'd2) begin
                    sync_cnt <= sync_cnt + 2'd1;
                end
            end else begin
                wr_addr <= sat_inc(wr_addr);
                if (HS) begin
                    hs_len <= sat_inc(hs_len);
                end
            end
            if (hs_fall) begin
                hs_out_len <= hs_len;
            end
        end
    end

    // On a sync edge the replay of the just-finished line starts in the same cycle,
    // so every line-dependent value is taken from its pre-edge source.
    always_comb begin
        line_len_eff = hs_rise ? wr_addr  : line_len;
        rd_base      = hs_rise ? '0       : rd_addr;
        rd_bank      = hs_rise ? wr_bank  : ~wr_bank;
        vbl_eff      = hs_rise ? vbl_line : vbl_prev;
        vld_eff      = hs_rise ? (sync_cnt != 2'd0) : (sync_cnt == 2'd2);
        short_eff    = line_len_eff < ADDR_TWO;
        ram_rd_addr  = {rd_bank, rd_base};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if (pxl2_cen) begin
            rd_addr <= wrap_inc(rd_base, line_len_eff);
        end else if (hs_rise) begin
            rd_addr <= '0;
        end
    end

    jtdd_scan2x_lbuf #(
        .HLEN (HLEN),
        .W    (WW)
    ) u_lbuf (
        .clk     (clk),
        .we      (pxl_cen),
        .wr_addr (ram_wr_addr),
        .wr_data (wr_word),
        .re      (pxl2_cen),
        .rd_addr (ram_rd_addr),
        .rd_data (word_p1)
    );

    // ---- stage p1: RAM word plus the sideband captured with the same read ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            short_p1 <= 1'b0;
            hs_p1    <= 1'b0;
            vbl_p1   <= 1'b0;
        end else if (pxl2_cen) begin
            vld_p1   <= vld_eff;
            short_p1 <= short_eff;
            hs_p1    <= rd_base < hs_out_len;
            vbl_p1   <= vbl_eff;
        end
    end

    always_comb begin
        lhbl_o = vld_p1 & ~short_p1 & word_p1[LHBL_BIT];
        lvbl_o = vld_p1 & vbl_p1;
        hs_o   = vld_p1 & hs_p1;
        rgb_o  = (lhbl_o & lvbl_o) ? word_p1[DW-1:0] : '0;
    end

    // ---- output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_red   <= '0;
            x_green <= '0;
            x_blue  <= '0;
            x_HS    <= 1'b0;
            x_LHBL  <= 1'b0;
            x_LVBL  <= 1'b0;
        end else begin
            x_red   <= rgb_o[DW-1 -: COLOR_W];
            x_green <= rgb_o[2*COLOR_W-1 -: COLOR_W];
            x_blue  <= rgb_o[COLOR_W-1:0];
            x_HS    <= hs_o;
            x_LHBL  <= lhbl_o;
            x_LVBL  <= lvbl_o;
        end
    end

endmodule

// File: tb/tb_jtdd_scan2x.sv
// Directed line sequences with random pixel data, checked every clock against a
// line-level model of the doubler (store a line, replay it modulo its length).
module tb_jtdd_scan2x;

    localparam int HLEN = 512;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b0;
    logic       pxl2_cen = 1'b0;
    logic [3:0] red = '0, green = '0, blue = '0;
    logic       HS = 1'b0, LHBL_dly = 1'b0, LVBL_dly = 1'b0;
    logic [3:0] x_red, x_green, x_blue;
    logic       x_HS, x_LHBL, x_LVBL;

    jtdd_scan2x #(.HLEN(HLEN), .DW(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .pxl2_cen (pxl2_cen),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .HS       (HS),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly),
        .x_red    (x_red),
        .x_green  (x_green),
        .x_blue   (x_blue),
        .x_HS     (x_HS),
        .x_LHBL   (x_LHBL),
        .x_LVBL   (x_LVBL)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the line being written, the line being replayed.
    logic [12:0] cur_mem  [HLEN];
    logic [12:0] prev_mem [HLEN];
    int          m_npix, m_prev_len, m_edges, m_j, m_hcnt, m_hsw;
    logic        m_hs_prev, m_cur_vbl, m_prev_vbl;
    logic [14:0] m_pend, m_out;   // {HS, LHBL, LVBL, rgb}
    logic [1:0]  ph = 2'd0;

    int n_hs, n_lhbl0, n_lvbl0, n_leak, n_active;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_npix     = 0;
        m_prev_len = 0;
        m_edges    = 0;
        m_j        = 0;
        m_hcnt     = 0;
        m_hsw      = 0;
        m_hs_prev  = 1'b0;
        m_cur_vbl  = 1'b0;
        m_prev_vbl = 1'b0;
        m_pend     = '0;
        m_out      = '0;
    endtask

    // Output for the j-th read since the last sync edge: pixel (j mod length) of the previous line.
    function automatic logic [14:0] m_read(input int hsw);
        int          addr;
        logic [12:0] w;
        logic        lh;
        logic [11:0] rgb;
        if (m_edges < 2) return '0;
        addr = (m_prev_len < 2) ? 0 : (m_j % m_prev_len);
        if (m_prev_len < 2) begin
            lh  = 1'b0;
            rgb = '0;
        end else begin
            w   = prev_mem[addr];
            lh  = w[12];
            rgb = (lh && m_prev_vbl) ? w[11:0] : 12'h000;
        end
        return {(addr < hsw), lh, m_prev_vbl, rgb};
    endfunction

    task automatic m_clock();
        int   hsw_before;
        int   idx;
        logic rise, fall;
        if (!rst_n) begin
            m_reset();
            return;
        end
        hsw_before = m_hsw;
        if (pxl_cen) begin
            rise = HS && !m_hs_prev;
            fall = !HS && m_hs_prev;
            if (rise) begin
                for (int k = 0; k < HLEN; k++) prev_mem[k] = cur_mem[k];
                m_prev_len = (m_npix > HLEN - 1) ? HLEN - 1 : m_npix;
                m_prev_vbl = m_cur_vbl;
                m_cur_vbl  = LVBL_dly;
                if (m_edges < 2) m_edges++;
                m_j    = 0;
                m_npix = 0;
                m_hcnt = 1;
            end else if (HS) begin
                m_hcnt++;
            end
            if (fall) m_hsw = m_hcnt;
            idx = (m_npix > HLEN - 1) ? HLEN - 1 : m_npix;
            cur_mem[idx] = {LHBL_dly, red, green, blue};
            m_npix++;
            m_hs_prev = HS;
        end
        m_out = m_pend;
        if (pxl2_cen) begin
            m_pend = m_read(hsw_before);
            m_j++;
        end
    endtask

    task automatic cycle();
        logic [14:0] obs;
        pxl_cen  = (ph == 2'd0);
        pxl2_cen = !ph[0];
        @(posedge clk);
        m_clock();
        #1;
        obs = {x_HS, x_LHBL, x_LVBL, x_red, x_green, x_blue};
        chk("x_out", 32'(obs), 32'(m_out));
        if (obs != '0) n_active++;
        if (ph[0]) begin
            if (x_HS) n_hs++;
            if (!x_LHBL) n_lhbl0++;
            if (!x_LVBL) n_lvbl0++;
            if (!x_LHBL && {x_red, x_green, x_blue} != 12'h000) n_leak++;
        end
        ph = ph + 2'd1;
    endtask

    task automatic drive_pixel(input logic hs, input logic lhbl, input logic lvbl, input logic [11:0] rgb);
        HS       = hs;
        LHBL_dly = lhbl;
        LVBL_dly = lvbl;
        {red, green, blue} = rgb;
        repeat (4) cycle();
    endtask

    task automatic run_line(input int len, input int hsw, input int nblank, input bit rnd, input logic lvbl);
        logic [11:0] v;
        n_hs = 0; n_lhbl0 = 0; n_lvbl0 = 0; n_leak = 0; n_active = 0;
        for (int i = 0; i < len; i++) begin
            if (i < nblank)  v = 12'hFFF;
            else if (rnd)    v = 12'($urandom);
            else             v = 12'(i);
            drive_pixel(i < hsw, i >= nblank, lvbl, v);
        end
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;
        drive_pixel(1'b0, 1'b1, 1'b1, 12'h000);
        chk("rst_rgb",  32'({x_red, x_green, x_blue}), 32'h0);
        chk("rst_hs",   32'(x_HS),   32'h0);
        chk("rst_lhbl", 32'(x_LHBL), 32'h0);
        chk("rst_lvbl", 32'(x_LVBL), 32'h0);
        rst_n = 1'b1;
        repeat (2) drive_pixel(1'b0, 1'b1, 1'b1, 12'h000);

        // Counting ramp 0x000..0x17F, sync 32 pixels wide
        run_line(384, 32, 0, 1'b0, 1'b1);
        chk("blank_first_line", 32'(n_active), 32'd0);
        run_line(384, 32, 0, 1'b0, 1'b1);
        chk("hs_reads_per_line", 32'(n_hs), 32'd64);
        chk("lhbl_ramp", 32'(n_lhbl0), 32'd0);

        // Blanked head of line carrying 0xFFF
        run_line(384, 32, 64, 1'b1, 1'b1);
        run_line(384, 32, 0, 1'b1, 1'b1);
        chk("lhbl0_reads", 32'(n_lhbl0), 32'd128);
        chk("rgb_leak", 32'(n_leak), 32'd0);

        // 383 then 384 pixel lines
        run_line(383, 32, 0, 1'b1, 1'b1);
        run_line(384, 32, 0, 1'b1, 1'b1);
        run_line(384, 32, 0, 1'b1, 1'b1);
        chk("hs_after_383", 32'(n_hs), 32'd64);

        // Missing sync: 600 pixels saturate the write address
        run_line(600, 32, 0, 1'b1, 1'b1);
        run_line(384, 32, 0, 1'b1, 1'b1);

        // Vertical blank start and its one-line delay
        run_line(384, 32, 0, 1'b1, 1'b1);
        run_line(384, 32, 0, 1'b1, 1'b0);
        chk("lvbl_before_fall", 32'(n_lvbl0), 32'd0);
        run_line(384, 32, 0, 1'b1, 1'b0);
        chk("lvbl_fall_line1", 32'(n_lvbl0), 32'd768);
        run_line(384, 32, 0, 1'b1, 1'b1);
        chk("lvbl_fall_line2", 32'(n_lvbl0), 32'd768);

        // Reset pulsed in the middle of a line
        run_line(200, 32, 0, 1'b1, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out", 32'({x_HS, x_LHBL, x_LVBL, x_red, x_green, x_blue}), 32'h0);
        repeat (2) drive_pixel(1'b0, 1'b1, 1'b1, 12'h000);
        rst_n = 1'b1;
        repeat (2) drive_pixel(1'b0, 1'b1, 1'b1, 12'h000);
        run_line(384, 32, 0, 1'b1, 1'b1);
        chk("blank_after_rst", 32'(n_active), 32'd0);
        run_line(384, 32, 0, 1'b1, 1'b1);
        chk("hs_resumed", 32'(n_hs), 32'd64);
        chk("lhbl_resumed", 32'(n_lhbl0), 32'd0);
        run_line(384, 32, 0, 1'b1, 1'b1);
        repeat (4) drive_pixel(1'b0, 1'b1, 1'b1, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtdd_scan2x.md
# jtdd_scan2x

Line-doubling scan converter placed directly downstream of the video top level. It takes the 15 kHz 4-4-4 RGB pixel stream, HS and delayed blanking signals, stores each input line in a ping-pong line buffer, and replays every stored line twice at double pixel rate. The result is a 31 kHz stream with regenerated HS and blanking for VGA-class outputs.

## Interface
- HLEN, 512: line-buffer depth per bank in pixels; power of two, at least the longest input line.
- DW, 12: RGB pixel width (4 bits red, green and blue).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pxl_cen  in  1  input pixel clock enable.
- pxl2_cen  in  1  output pixel clock enable; exactly two pulses per pxl_cen period.
- red, green, blue  in  4 each  input pixel.
- HS  in  1  input horizontal sync, active high.
- LHBL_dly  in  1  input horizontal blank, active low.
- LVBL_dly  in  1  input vertical blank, active low.
- x_red, x_green, x_blue  out  4 each  doubled pixel.
- x_HS  out  1  output horizontal sync, active high.
- x_LHBL  out  1  output horizontal blank, active low.
- x_LVBL  out  1  output vertical blank, active low.

## Operation
- Storage: two banks of HLEN words, each DW+1 bits (the pixel plus LHBL_dly).
- Write side, on pxl_cen:
  - Store {LHBL_dly, red, green, blue} at wr_addr in bank wr_bank.
  - Increment wr_addr, saturating at HLEN-1. Pixels beyond that overwrite the last word.
- HS rising edge, sampled on pxl_cen:
  - line_len <= wr_addr.
  - wr_bank toggles; wr_addr <= 0.
  - hs_len counts input pixels while HS is high; it is latched into hs_out_len on the falling edge.
  - vbl_line <= LVBL_dly sampled at the edge.
- The pixel written on the same pxl_cen as the HS edge goes to address 0 of the new bank.
- Read side, on pxl2_cen:
  - Read bank ~wr_bank at rd_addr.
  - rd_addr increments; at line_len-1 it wraps to 0, which starts the second replay.
  - An input HS edge forces rd_addr <= 0 regardless of position, so output lines stay locked to input lines.
- Outputs:
  - x_HS is high while rd_addr < hs_out_len, in both replays, which halves the sync width in time.
  - x_LHBL comes from the stored bit.
  - x_LVBL = vbl_line, delayed one input line to stay aligned with the replayed data.
  - RGB is forced to 0 when the stored LHBL bit is 0 or x_LVBL is 0.
- line_len < 2: the read side holds rd_addr at 0 and outputs a blank pixel (0 with x_LHBL = 0).

## Timing
- Reset values: every output 0; wr_addr, rd_addr, wr_bank, line_len, hs_len, hs_out_len and vbl_line all 0.
- Reset is asynchronous on assertion. Deassertion is sampled on clk; logic resumes at the next enable.
- Reset mid-line discards partial buffer state; the first valid output follows the second HS edge after release.
- RAM read is registered (1 clk) and the output register adds 1 clk.
- Input pixel at address k of line N appears on x_* 2 clk after the pxl2_cen that reads address k. That pxl2_cen occurs during input line N+1, first and second replay.
- Simultaneous HS edge and the rd_addr wrap: the HS reset wins.

## Structure
- Shared package jtdd_scan2x_pkg:
  - default HLEN;
  - pixel/word width constants;
  - localparam for the RAM word layout (LHBL bit at MSB).
- Sub-module jtdd_scan2x_lbuf holds the storage:
  - simple dual-port RAM, depth 2*HLEN, with a single write port and a registered read port;
  - the bank select is the address MSB.
- Everything else (counters, edge detectors, output regs) lives in jtdd_scan2x.

## Test plan
- Line of 384 pixels, values 0x000..0x17F, HS 32 pixels wide:
  - the next input line shows that sequence twice on x_*, each pixel lasting 1 pxl_cen period / 2;
  - x_HS is high for 32 pxl2_cen pulses at the start of each replay.
- Stored LHBL bit 0 at pixels 0..63 with pixel data 0xFFF: x_LHBL = 0 and RGB = 0 for the first 64 output pixels of each replay.
- Missing HS for 600 pixels with HLEN = 512: wr_addr holds at 511; the next HS sets line_len = 511 with no wrap corruption of address 0.
- Input line length 383 followed by 384: rd_addr wraps at 382, then at 383; no pixel is repeated or dropped.
- LVBL_dly falls at line 240: x_LVBL falls at the start of the replay of line 240 (one input line later) and lasts two output lines per input line.
- rst_n pulsed low mid-line:
  - all outputs read 0 immediately;
  - after release, the outputs stay blank until the second HS edge, then doubling resumes correctly.
